// File: rtl/ascon_pkg.sv
// Shared widths and the release FSM state type for the Ascon plaintext release path.
package ascon_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTES_W = 5;
  localparam int TAG_W   = 128;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    WAIT_TAG = 3'd2,
    COMPARE  = 3'd3,
    RELEASE  = 3'd4,
    DISCARD  = 3'd5
  } state_t;
endpackage

// File: rtl/ascon_block_fifo.sv
// Circular block store (data, valid byte count, last flag) with clear and per-entry zeroize.
module ascon_block_fifo
  import ascon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [BLOCK_W-1:0]         push_data,
  input  logic [BYTES_W-1:0]         push_bytes,
  input  logic                       push_last,
  input  logic                       pop,
  output logic [BLOCK_W-1:0]         head_data,
  output logic [BYTES_W-1:0]         head_bytes,
  output logic                       head_last,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       zero_en,
  input  logic [$clog2(DEPTH)-1:0]   zero_idx
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);

  logic [BLOCK_W-1:0] data_mem  [DEPTH];
  logic [BYTES_W-1:0] bytes_mem [DEPTH];
  logic               last_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (zero_en) begin
      data_mem[zero_idx]  <= '0;
      bytes_mem[zero_idx] <= '0;
      last_mem[zero_idx]  <= 1'b0;
    end else if (push) begin
      data_mem[wr_ptr_q]  <= push_data;
      bytes_mem[wr_ptr_q] <= push_bytes;
      last_mem[wr_ptr_q]  <= push_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + ONE_CNT;
        2'b01:   count_q <= count_q - ONE_CNT;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data  = data_mem[rd_ptr_q];
  assign head_bytes = bytes_mem[rd_ptr_q];
  assign head_last  = last_mem[rd_ptr_q];
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign count      = count_q;
endmodule

// File: rtl/ascon_plaintext_release.sv
// Holds decrypted blocks until the tag compare passes, then releases them; drops them on mismatch.
// Define ASCON_RELEASE_ZEROIZE_EN to scrub every buffer entry before returning to IDLE on discard.
module ascon_plaintext_release
  import ascon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pt_valid,
  output logic               pt_ready,
  input  logic [BLOCK_W-1:0] pt_data,
  input  logic [BYTES_W-1:0] pt_bytes,
  input  logic               pt_last,
  input  logic               tag_valid,
  input  logic [TAG_W-1:0]   tag,
  input  logic               exp_tag_valid,
  input  logic [TAG_W-1:0]   exp_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [BYTES_W-1:0] out_bytes,
  output logic               out_last,
  output logic               auth_done,
  output logic               auth_ok,
  output logic               err_overflow,
  output state_t             dbg_state
);
  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // the source holds data stable while valid=1 and ready=0.
  localparam int PTR_W = $clog2(DEPTH);

  state_t state_q, state_d;

  logic [TAG_W-1:0] tag_q, exp_tag_q;
  logic             tag_seen_q, exp_seen_q;
  logic             auth_ok_q;
  logic             tags_ready, tags_match;

  logic             pt_ready_c, out_valid_c;
  logic             fifo_push, fifo_pop, fifo_clear, zero_en;
  logic [PTR_W-1:0] zero_idx;
  logic             fifo_full, fifo_empty;
  logic [PTR_W:0]   fifo_count;
  logic [BLOCK_W-1:0] head_data;
  logic [BYTES_W-1:0] head_bytes;
  logic               head_last;

  ascon_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_data  (pt_data),
    .push_bytes (pt_bytes),
    .push_last  (pt_last),
    .pop        (fifo_pop),
    .head_data  (head_data),
    .head_bytes (head_bytes),
    .head_last  (head_last),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .zero_en    (zero_en),
    .zero_idx   (zero_idx)
  );

  // A strobe arriving this cycle counts as latched for the next-state decision.
  assign tags_ready = (tag_seen_q | tag_valid) & (exp_seen_q | exp_tag_valid);
  assign tags_match = (tag_q == exp_tag_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      exp_tag_q  <= '0;
      tag_seen_q <= 1'b0;
      exp_seen_q <= 1'b0;
    end else if (state_q == IDLE) begin
      tag_seen_q <= 1'b0;
      exp_seen_q <= 1'b0;
    end else begin
      if (tag_valid) begin
        tag_q      <= tag;
        tag_seen_q <= 1'b1;
      end
      if (exp_tag_valid) begin
        exp_tag_q  <= exp_tag;
        exp_seen_q <= 1'b1;
      end
    end
  end

`ifdef ASCON_RELEASE_ZEROIZE_EN
  logic [PTR_W-1:0] zero_idx_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     zero_idx_q <= '0;
    else if (state_q == DISCARD) zero_idx_q <= zero_idx_q + PTR_W'(1);
    else                         zero_idx_q <= '0;
  end
  assign zero_idx = zero_idx_q;
`else
  assign zero_idx = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pt_ready_c   = 1'b0;
    out_valid_c  = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_clear   = 1'b0;
    zero_en      = 1'b0;
    auth_done    = 1'b0;
    err_overflow = 1'b0;
    case (state_q)
      IDLE: begin
        pt_ready_c = 1'b1;
        if (pt_valid) begin
          fifo_push = 1'b1;
          state_d   = pt_last ? WAIT_TAG : COLLECT;
        end
      end
      COLLECT: begin
        if (fifo_full) begin
          err_overflow = 1'b1;
          state_d      = DISCARD;
        end else begin
          pt_ready_c = 1'b1;
          if (pt_valid) begin
            fifo_push = 1'b1;
            if (pt_last) state_d = tags_ready ? COMPARE : WAIT_TAG;
          end
        end
      end
      WAIT_TAG: begin
        if (tags_ready) state_d = COMPARE;
      end
      COMPARE: begin
        auth_done = 1'b1;
        state_d   = tags_match ? RELEASE : DISCARD;
      end
      RELEASE: begin
        out_valid_c = !fifo_empty;
        if (out_valid_c && out_ready) begin
          fifo_pop = 1'b1;
          if (fifo_count == (PTR_W + 1)'(1)) state_d = IDLE;
        end
      end
      DISCARD: begin
`ifdef ASCON_RELEASE_ZEROIZE_EN
        zero_en = 1'b1;
        if (zero_idx == PTR_W'(DEPTH - 1)) begin
          fifo_clear = 1'b1;
          state_d    = IDLE;
        end
`else
        fifo_clear = 1'b1;
        state_d    = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // auth_ok reflects the live compare during COMPARE, then holds until a new message starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              auth_ok_q <= 1'b0;
    else if (state_q == COMPARE)          auth_ok_q <= tags_match;
    else if (state_q == IDLE && pt_valid) auth_ok_q <= 1'b0;
  end

  assign auth_ok   = (state_q == COMPARE) ? tags_match : auth_ok_q;
  assign pt_ready  = pt_ready_c & ~rst;
  assign out_valid = out_valid_c;
  assign out_data  = out_valid_c ? head_data  : '0;
  assign out_bytes = out_valid_c ? head_bytes : '0;
  assign out_last  = out_valid_c ? head_last  : 1'b0;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ascon_plaintext_release.sv
// Directed bench for ascon_plaintext_release: message-level model plus per-cycle output compare.
module tb_ascon_plaintext_release;
  import ascon_pkg::*;

  localparam int DEPTH = 4;
  localparam int EW    = 1 + BYTES_W + BLOCK_W;
`ifdef ASCON_RELEASE_ZEROIZE_EN
  localparam int DISCARD_TO_IDLE = DEPTH + 1;
`else
  localparam int DISCARD_TO_IDLE = 2;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               pt_valid, pt_ready, pt_last;
  logic [BLOCK_W-1:0] pt_data;
  logic [BYTES_W-1:0] pt_bytes;
  logic               tag_valid, exp_tag_valid;
  logic [TAG_W-1:0]   tag, exp_tag;
  logic               out_valid, out_ready, out_last;
  logic [BLOCK_W-1:0] out_data;
  logic [BYTES_W-1:0] out_bytes;
  logic               auth_done, auth_ok, err_overflow;
  state_t             dbg_state;

  ascon_plaintext_release #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_bytes(pt_bytes), .pt_last(pt_last),
    .tag_valid(tag_valid), .tag(tag), .exp_tag_valid(exp_tag_valid), .exp_tag(exp_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
    .out_last(out_last), .auth_done(auth_done), .auth_ok(auth_ok), .err_overflow(err_overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0, n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] msg_q[$];
  bit            auth_q[$];
  logic [TAG_W-1:0] m_tag, m_exp;
  bit            m_tag_seen, m_exp_seen, m_last_seen;
  int            beats = 0, auths = 0, ovfs = 0;
  logic [BYTES_W-1:0] last_beat_bytes;
  logic          last_beat_last;
  bit            prev_stall = 0;
  logic [EW-1:0] prev_beat;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event did not occur, required it within bound", name);
  endtask

  task automatic model_reset();
    msg_q.delete();
    m_tag_seen  = 0;
    m_exp_seen  = 0;
    m_last_seen = 0;
  endtask

  // Once a message is complete and both tags are known, its fate is decided.
  task automatic model_step();
    if (m_last_seen && m_tag_seen && m_exp_seen) begin
      auth_q.push_back(m_tag == m_exp);
      if (m_tag == m_exp) foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
      model_reset();
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {{(EW-1){1'b0}}, out_valid}, 1);
        check("stall_data_held", {out_last, out_bytes, out_data}, prev_beat);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {out_last, out_bytes, out_data});
        end else begin
          check("beat", {out_last, out_bytes, out_data}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (out_ready) begin
          beats++;
          last_beat_bytes = out_bytes;
          last_beat_last  = out_last;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_last, out_bytes, out_data};
      if (auth_done) begin
        auths++;
        if (auth_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_auth: got auth_done=1 expected none");
        end else begin
          check("auth_ok_at_compare", {{(EW-1){1'b0}}, auth_ok}, {{(EW-1){1'b0}}, auth_q.pop_front()});
        end
      end
      if (err_overflow) ovfs++;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [BLOCK_W-1:0] blk(input int m, input int i);
    return {32'(m), 32'(i), 32'hA5C3_0F00 ^ 32'(i), 32'h1234_5678 + 32'(m * 16 + i)};
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input int m);
    return {4{32'hDEAD_0000 | 32'(m)}};
  endfunction

  task automatic send_block(input logic [BLOCK_W-1:0] d, input logic [BYTES_W-1:0] b, input logic l);
    bit done;
    done     = 0;
    pt_valid = 1'b1;
    pt_data  = d;
    pt_bytes = b;
    pt_last  = l;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pt_ready) begin
        done = 1;
        msg_q.push_back({l, b, d});
      end
      @(posedge clk);
      #1;
    end
    pt_valid = 1'b0;
    pt_last  = 1'b0;
    if (!done) fail_now("pt_accept_timeout");
    else if (l) begin
      m_last_seen = 1;
      model_step();
    end
  endtask

  task automatic send_msg(input int m, input int n, input logic [BYTES_W-1:0] last_bytes);
    for (int i = 0; i < n; i++)
      send_block(blk(m, i), (i == n - 1) ? last_bytes : 5'd16, i == n - 1);
  endtask

  task automatic send_tags(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] e, input bit same);
    tag_valid = 1'b1;
    tag       = t;
    if (same) begin
      exp_tag_valid = 1'b1;
      exp_tag       = e;
    end
    @(posedge clk);
    #1;
    tag_valid = 1'b0;
    if (!same) begin
      exp_tag_valid = 1'b1;
      exp_tag       = e;
      @(posedge clk);
      #1;
    end
    exp_tag_valid = 1'b0;
    m_tag = t;
    m_exp = e;
    m_tag_seen = 1;
    m_exp_seen = 1;
    model_step();
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state == IDLE && exp_q.size() == 0) done = 1;
    end
    if (!done) fail_now(name);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b0, o0, n;
    bit found;
    rst = 1'b1;
    pt_valid = 0; pt_data = '0; pt_bytes = '0; pt_last = 0;
    tag_valid = 0; tag = '0; exp_tag_valid = 0; exp_tag = '0;
    out_ready = 1'b1;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_pt_ready", pt_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_bytes", out_bytes, 0);
    check("rst_out_last", out_last, 0);
    check("rst_auth_done", auth_done, 0);
    check("rst_auth_ok", auth_ok, 0);
    check("rst_err_overflow", err_overflow, 0);
    rst = 1'b0;
    #1;
    check("idle_pt_ready", pt_ready, 1);
    @(posedge clk);
    #1;

    // 62-byte message, matching tags
    b0 = beats;
    send_msg(1, 4, 5'd14);
    @(negedge clk);
    check("wait_tag_pt_ready", pt_ready, 0);
    @(posedge clk);
    #1;
    send_tags(tag_of(1), tag_of(1), 0);
    wait_idle("t1_release_done");
    check("t1_beats", beats - b0, 4);
    check("t1_last_bytes", last_beat_bytes, 14);
    check("t1_last_flag", last_beat_last, 1);
    check("t1_auth_ok_held", auth_ok, 1);

    // same message, expected tag differs in bit 0
    b0 = beats;
    send_msg(1, 4, 5'd14);
    send_tags(tag_of(1), tag_of(1) ^ 128'd1, 0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (auth_done) found = 1;
    end
    if (!found) fail_now("t2_auth_done");
    n = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      n++;
      if (dbg_state == IDLE) found = 1;
    end
    check("t2_discard_to_idle_cycles", n, DISCARD_TO_IDLE);
    check("t2_auth_ok_held", auth_ok, 0);
    @(posedge clk);
    #1;
    check("t2_beats", beats - b0, 0);

    // overflow: four blocks without pt_last, fifth presented
    b0 = beats;
    o0 = ovfs;
    for (int i = 0; i < 4; i++) send_block(blk(3, i), 5'd16, 1'b0);
    pt_valid = 1'b1;
    pt_data  = blk(3, 4);
    pt_bytes = 5'd16;
    pt_last  = 1'b0;
    @(negedge clk);
    check("t3_err_overflow", err_overflow, 1);
    check("t3_pt_ready_full", pt_ready, 0);
    @(posedge clk);
    #1;
    pt_valid = 1'b0;
    model_reset();
    wait_idle("t3_back_to_idle");
    check("t3_overflow_pulses", ovfs - o0, 1);
    check("t3_beats", beats - b0, 0);

    // tags before pt_last, both in the same cycle
    b0 = beats;
    send_block(blk(4, 0), 5'd16, 1'b0);
    send_block(blk(4, 1), 5'd16, 1'b0);
    send_tags(tag_of(4), tag_of(4), 1);
    send_block(blk(4, 2), 5'd9, 1'b1);
    @(negedge clk);
    check("t4_compare_next_cycle", auth_done, 1);
    @(negedge clk);
    check("t4_out_valid_latency2", out_valid, 1);
    wait_idle("t4_release_done");
    check("t4_beats", beats - b0, 3);

    // out_ready toggling during release
    b0 = beats;
    out_ready = 1'b0;
    send_msg(5, 4, 5'd16);
    send_tags(tag_of(5), tag_of(5), 0);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      @(posedge clk);
      #1;
      if (dbg_state == IDLE) break;
    end
    out_ready = 1'b1;
    wait_idle("t5_release_done");
    check("t5_beats", beats - b0, 4);

    // reset after the second release beat
    b0 = beats;
    send_msg(6, 4, 5'd16);
    send_tags(tag_of(6), tag_of(6), 0);
    for (int i = 0; i < 20 && (beats - b0) < 2; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_beats_before_rst", beats - b0, 2);
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_out_bytes", out_bytes, 0);
    check("t6_out_last", out_last, 0);
    check("t6_auth_ok", auth_ok, 0);
    check("t6_pt_ready", pt_ready, 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    b0 = beats;
    send_msg(7, 4, 5'd16);
    send_tags(tag_of(7), tag_of(7), 0);
    wait_idle("t7_release_done");
    check("t7_beats", beats - b0, 4);
    check("t7_auth_ok", auth_ok, 1);

    // end-of-run accounting
    repeat (3) @(posedge clk);
    #1;
    check("auth_count", auths, 6);
    check("overflow_count", ovfs, 1);
    check("exp_q_drained", exp_q.size(), 0);
    check("auth_q_drained", auth_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
